// File: rtl/arp_request_responder.sv
// arp_request_responder: parses the MII RX nibble stream, recognises ARP
// requests for the board IP, builds the 60-byte ARP reply in the TX frame RAM
// and then kicks the nibble transmitter with a one-cycle tx_start.
module arp_request_responder #(
  parameter int MIN_FRAME_BYTES = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx_dv,
  input  logic [3:0]  rx_data,
  input  logic [47:0] BOARD_MAC,
  input  logic [31:0] BOARD_IP,
  input  logic        tx_busy,
  output logic [5:0]  ram_wr_addr,
  output logic [7:0]  ram_wr_data,
  output logic        ram_wren,
  output logic        tx_start,
  output logic [47:0] PC_MAC,
  output logic [31:0] PC_IP,
  output logic [15:0] arp_req_cnt
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, RECV, DROP, CHECK, PEND, WRITE, START} state_t;

  localparam logic [8:0] MIN_B = 9'(MIN_FRAME_BYTES);

  state_t      state;
  logic [7:0]  byte_idx;
  logic        phase;      // 1 = low nibble of the current byte already held
  logic [3:0]  lo_nib;
  logic        reject;     // sticky field mismatch
  logic        bcast_ok;   // dest MAC so far is all FF
  logic        mac_ok;     // dest MAC so far equals BOARD_MAC
  logic [47:0] sh_mac;
  logic [31:0] sh_ip;

  // Byte views so fields can be indexed MSB-first by offset.
  logic [5:0][7:0] bmac_v, pcmac_v;
  logic [3:0][7:0] bip_v, pcip_v;
  assign bmac_v  = BOARD_MAC;
  assign pcmac_v = PC_MAC;
  assign bip_v   = BOARD_IP;
  assign pcip_v  = PC_IP;

  logic [7:0] rx_byte;
  assign rx_byte = {rx_data, lo_nib};

  // Fixed ARP header bytes 12..21; only the opcode differs between request and reply.
  function automatic logic [7:0] arp_const(input logic [7:0] idx, input logic reply);
    case (idx)
      8'd12:   return 8'h08;
      8'd13:   return 8'h06;
      8'd14:   return 8'h00;
      8'd15:   return 8'h01;
      8'd16:   return 8'h08;
      8'd17:   return 8'h00;
      8'd18:   return 8'h06;
      8'd19:   return 8'h04;
      8'd20:   return 8'h00;
      8'd21:   return reply ? 8'h02 : 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  // Receive-side field check of the byte completing this cycle.
  logic       field_bad;
  logic [7:0] mac_b;
  always_comb begin
    field_bad = 1'b0;
    mac_b     = bmac_v[3'(8'd5 - byte_idx)];
    if (byte_idx >= 8'd12 && byte_idx <= 8'd21)
      field_bad = rx_byte != arp_const(byte_idx, 1'b0);
    else if (byte_idx >= 8'd38 && byte_idx <= 8'd41)
      field_bad = rx_byte != bip_v[2'(8'd41 - byte_idx)];
  end

  // Reply byte for the next RAM address to be written.
  logic [5:0] nxt_addr;
  logic [7:0] tx_byte;
  assign nxt_addr = (state == WRITE) ? ram_wr_addr + 6'd1 : 6'd0;
  always_comb begin
    tx_byte = 8'h00;
    if      (nxt_addr <= 6'd5)  tx_byte = pcmac_v[3'(6'd5  - nxt_addr)];
    else if (nxt_addr <= 6'd11) tx_byte = bmac_v[3'(6'd11 - nxt_addr)];
    else if (nxt_addr <= 6'd21) tx_byte = arp_const({2'b00, nxt_addr}, 1'b1);
    else if (nxt_addr <= 6'd27) tx_byte = bmac_v[3'(6'd27 - nxt_addr)];
    else if (nxt_addr <= 6'd31) tx_byte = bip_v[2'(6'd31 - nxt_addr)];
    else if (nxt_addr <= 6'd37) tx_byte = pcmac_v[3'(6'd37 - nxt_addr)];
    else if (nxt_addr <= 6'd41) tx_byte = pcip_v[2'(6'd41 - nxt_addr)];
  end

  // Main FSM: frame parse, accept decision, reply write-out and start strobe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      byte_idx    <= '0;
      phase       <= 1'b0;
      lo_nib      <= '0;
      reject      <= 1'b0;
      bcast_ok    <= 1'b0;
      mac_ok      <= 1'b0;
      sh_mac      <= '0;
      sh_ip       <= '0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      ram_wren    <= 1'b0;
      tx_start    <= 1'b0;
      PC_MAC      <= '0;
      PC_IP       <= '0;
      arp_req_cnt <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        // Anything but a preamble nibble here is the tail of a frame we missed.
        IDLE: if (rx_dv) state <= (rx_data == 4'h5) ? PREAMBLE : DROP;
        PREAMBLE: begin
          if (!rx_dv) state <= DROP;
          else if (rx_data == 4'hD) begin
            state    <= RECV;
            byte_idx <= '0;
            phase    <= 1'b0;
            reject   <= 1'b0;
            bcast_ok <= 1'b1;
            mac_ok   <= 1'b1;
          end else if (rx_data != 4'h5) state <= DROP;
        end
        RECV: begin
          if (!rx_dv) state <= CHECK;
          else if (!phase) begin
            lo_nib <= rx_data;
            phase  <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (byte_idx != 8'hFF) byte_idx <= byte_idx + 8'd1;
            if (byte_idx <= 8'd5) begin
              if (rx_byte != 8'hFF) bcast_ok <= 1'b0;
              if (rx_byte != mac_b) mac_ok   <= 1'b0;
            end
            if (field_bad) reject <= 1'b1;
            if (byte_idx >= 8'd22 && byte_idx <= 8'd27) sh_mac <= {sh_mac[39:0], rx_byte};
            if (byte_idx >= 8'd28 && byte_idx <= 8'd31) sh_ip  <= {sh_ip[23:0], rx_byte};
          end
        end
        CHECK: begin
          if (!reject && !phase && (bcast_ok || mac_ok) && {1'b0, byte_idx} >= MIN_B) begin
            PC_MAC      <= sh_mac;
            PC_IP       <= sh_ip;
            arp_req_cnt <= arp_req_cnt + 16'd1;
            state       <= PEND;
          end else state <= IDLE;
        end
        DROP: if (!rx_dv) state <= IDLE;
        PEND: begin
          if (!tx_busy) begin
            state       <= WRITE;
            ram_wren    <= 1'b1;
            ram_wr_addr <= nxt_addr;
            ram_wr_data <= tx_byte;
          end
        end
        WRITE: begin
          if (ram_wr_addr == 6'd59) begin
            ram_wren <= 1'b0;
            tx_start <= 1'b1;
            state    <= START;
          end else begin
            ram_wr_addr <= nxt_addr;
            ram_wr_data <= tx_byte;
          end
        end
        START:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arp_request_responder.sv
// Directed bench for arp_request_responder: scoreboarded reply writes,
// rejection cases, tx_busy back-pressure and reset in the middle of a write.
module tb_arp_request_responder;

  localparam logic [47:0] BMAC  = 48'h02_00_00_AB_CD_EF;
  localparam logic [31:0] BIP   = 32'hC0A80101;
  localparam logic [47:0] SMAC  = 48'h00_11_22_33_44_55;
  localparam logic [31:0] SIP   = 32'hC0A8010A;
  localparam logic [47:0] SMAC2 = 48'hA0_B1_C2_D3_E4_F5;
  localparam logic [31:0] SIP2  = 32'hC0A80177;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_dv = 1'b0;
  logic [3:0]  rx_data = 4'h0;
  logic        tx_busy = 1'b0;
  logic [5:0]  ram_wr_addr;
  logic [7:0]  ram_wr_data;
  logic        ram_wren, tx_start;
  logic [47:0] PC_MAC;
  logic [31:0] PC_IP;
  logic [15:0] arp_req_cnt;

  arp_request_responder #(.MIN_FRAME_BYTES(64)) dut (
    .clock(clock), .reset_n(reset_n), .rx_dv(rx_dv), .rx_data(rx_data),
    .BOARD_MAC(BMAC), .BOARD_IP(BIP), .tx_busy(tx_busy),
    .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data), .ram_wren(ram_wren),
    .tx_start(tx_start), .PC_MAC(PC_MAC), .PC_IP(PC_IP), .arp_req_cnt(arp_req_cnt)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: logs every RAM write and start strobe shortly after the edge.
  logic [13:0] act_q[$];
  logic [7:0]  ram [0:63];
  int wr_cnt = 0, start_cnt = 0, first_wr_cyc = 0, last_wr_cyc = 0, start_cyc = 0;
  always @(posedge clock) begin
    #2;
    if (ram_wren) begin
      act_q.push_back({ram_wr_addr, ram_wr_data});
      ram[ram_wr_addr] = ram_wr_data;
      wr_cnt++;
      if (ram_wr_addr == 6'd0)  first_wr_cyc = cyc;
      if (ram_wr_addr == 6'd59) last_wr_cyc  = cyc;
    end
    if (tx_start) begin
      start_cnt++;
      start_cyc = cyc;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int errors = 0, checks = 0;
  logic [13:0] exp_q[$];
  int rd_idx = 0;
  logic [7:0] frame [0:63];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build(input logic [47:0] dmac, input logic [15:0] et, input logic [7:0] op,
                       input logic [47:0] smac, input logic [31:0] sip, input logic [31:0] tip);
    for (int i = 0; i < 64; i++) frame[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      frame[i]      = dmac[8*(5-i) +: 8];
      frame[6+i]    = smac[8*(5-i) +: 8];
      frame[22+i]   = smac[8*(5-i) +: 8];
    end
    frame[12] = et[15:8]; frame[13] = et[7:0];
    frame[14] = 8'h00; frame[15] = 8'h01; frame[16] = 8'h08; frame[17] = 8'h00;
    frame[18] = 8'h06; frame[19] = 8'h04; frame[20] = 8'h00; frame[21] = op;
    for (int i = 0; i < 4; i++) begin
      frame[28+i] = sip[8*(3-i) +: 8];
      frame[38+i] = tip[8*(3-i) +: 8];
    end
  endtask

  task automatic put(input logic [3:0] n);
    rx_dv = 1'b1; rx_data = n;
    @(negedge clock);
  endtask

  task automatic send(input int nbytes, input bit odd, output int t_end);
    for (int i = 0; i < 15; i++) put(4'h5);
    put(4'hD);
    for (int i = 0; i < nbytes; i++) begin
      put(frame[i][3:0]);
      put(frame[i][7:4]);
    end
    if (odd) put(4'h0);
    rx_dv = 1'b0; rx_data = 4'h0;
    t_end = cyc;
  endtask

  // Expected reply image, pushed to the scoreboard.
  task automatic push_reply(input logic [47:0] pmac, input logic [31:0] pip);
    logic [7:0] rep [0:59];
    logic [7:0] hdr [0:9] = '{8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h02};
    for (int a = 0; a < 60; a++) rep[a] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      rep[i] = pmac[8*(5-i) +: 8]; rep[6+i] = BMAC[8*(5-i) +: 8];
      rep[22+i] = BMAC[8*(5-i) +: 8]; rep[32+i] = pmac[8*(5-i) +: 8];
    end
    for (int i = 0; i < 10; i++) rep[12+i] = hdr[i];
    for (int i = 0; i < 4; i++) begin
      rep[28+i] = BIP[8*(3-i) +: 8]; rep[38+i] = pip[8*(3-i) +: 8];
    end
    for (int a = 0; a < 60; a++) exp_q.push_back({6'(a), rep[a]});
  endtask

  task automatic score(input string tag);
    logic [13:0] e;
    chk({tag, "_nwr"}, act_q.size() - rd_idx, exp_q.size());
    while (exp_q.size() > 0 && rd_idx < act_q.size()) begin
      e = exp_q.pop_front();
      chk(tag, act_q[rd_idx], e);
      rd_idx++;
    end
    exp_q.delete();
    rd_idx = act_q.size();
  endtask

  task automatic wait_start(input int s0, input string tag);
    int n = 0;
    while (start_cnt == s0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    repeat (3) @(negedge clock);
    chk(tag, start_cnt - s0, 1);
  endtask

  task automatic reject_case(input string tag, input int nbytes, input bit odd);
    int w0, s0, t;
    w0 = wr_cnt; s0 = start_cnt;
    send(nbytes, odd, t);
    repeat (150) @(negedge clock);
    chk({tag, "_wr"}, wr_cnt - w0, 0);
    chk({tag, "_start"}, start_cnt - s0, 0);
  endtask

  initial begin
    int t_end, s0, w0, c0, n;
    bit hit;

    repeat (3) @(negedge clock);
    chk("rst_addr", ram_wr_addr, 0);
    chk("rst_data", ram_wr_data, 0);
    chk("rst_wren", ram_wren, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_pcmac", PC_MAC, 0);
    chk("rst_pcip", PC_IP, 0);
    chk("rst_cnt", arp_req_cnt, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Broadcast request for the board IP.
    build(BCAST, 16'h0806, 8'h01, SMAC, SIP, BIP);
    push_reply(SMAC, SIP);
    s0 = start_cnt;
    send(64, 1'b0, t_end);
    wait_start(s0, "t1_start");
    chk("t1_first_lat", first_wr_cyc, t_end + 3);
    chk("t1_start_lat", start_cyc, last_wr_cyc + 1);
    chk("t1_burst", start_cyc - first_wr_cyc, 60);
    score("t1_wr");
    chk("t1_ram0_5", {ram[0], ram[1], ram[2], ram[3], ram[4], ram[5]}, 48'h001122334455);
    chk("t1_ram21", ram[21], 8'h02);
    chk("t1_ram38_41", {ram[38], ram[39], ram[40], ram[41]}, 32'hC0A8010A);
    chk("t1_cnt", arp_req_cnt, 1);
    chk("t1_pcmac", PC_MAC, SMAC);
    chk("t1_pcip", PC_IP, SIP);

    // Rejections: wrong target IP, reply opcode, IP ethertype, foreign dest MAC.
    build(BCAST, 16'h0806, 8'h01, SMAC2, SIP2, 32'hC0A80102);
    reject_case("t2_tip", 64, 1'b0);
    chk("t2_pcmac", PC_MAC, SMAC);
    chk("t2_cnt", arp_req_cnt, 1);
    build(BCAST, 16'h0806, 8'h02, SMAC2, SIP2, BIP);
    reject_case("t3_reply", 64, 1'b0);
    build(BCAST, 16'h0800, 8'h01, SMAC2, SIP2, BIP);
    reject_case("t4_etype", 64, 1'b0);
    build(48'h02_00_00_AB_CD_EE, 16'h0806, 8'h01, SMAC2, SIP2, BIP);
    reject_case("t5_dmac", 64, 1'b0);
    chk("t5_cnt", arp_req_cnt, 1);

    // Unicast request while the transmitter is busy.
    tx_busy = 1'b1;
    build(BMAC, 16'h0806, 8'h01, SMAC2, SIP2, BIP);
    push_reply(SMAC2, SIP2);
    w0 = wr_cnt; s0 = start_cnt;
    send(64, 1'b0, t_end);
    repeat (200) @(negedge clock);
    chk("t6_hold_wr", wr_cnt - w0, 0);
    chk("t6_cnt", arp_req_cnt, 2);
    c0 = cyc;
    tx_busy = 1'b0;
    wait_start(s0, "t6_start");
    chk("t6_first_lat", first_wr_cyc, c0 + 1);
    score("t6_wr");
    chk("t6_pcmac", PC_MAC, SMAC2);
    chk("t6_pcip", PC_IP, SIP2);

    // Short frame and odd nibble count, then a good one.
    build(BCAST, 16'h0806, 8'h01, SMAC, SIP, BIP);
    reject_case("t7_short", 50, 1'b0);
    reject_case("t8_odd", 64, 1'b1);
    chk("t8_cnt", arp_req_cnt, 2);
    push_reply(SMAC, SIP);
    s0 = start_cnt;
    send(64, 1'b0, t_end);
    wait_start(s0, "t9_start");
    score("t9_wr");
    chk("t9_cnt", arp_req_cnt, 3);

    // Reset in the middle of the reply write.
    s0 = start_cnt;
    send(64, 1'b0, t_end);
    hit = 1'b0; n = 0;
    while (!hit && n < 200) begin
      @(negedge clock);
      n++;
      hit = ram_wren && (ram_wr_addr == 6'd30);
    end
    chk("t10_reach30", hit, 1);
    reset_n = 1'b0;
    #1;
    chk("t10_wren", ram_wren, 0);
    chk("t10_addr", ram_wr_addr, 0);
    chk("t10_data", ram_wr_data, 0);
    chk("t10_start", tx_start, 0);
    chk("t10_pcmac", PC_MAC, 0);
    chk("t10_pcip", PC_IP, 0);
    chk("t10_cnt", arp_req_cnt, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (100) @(negedge clock);
    chk("t10_nostart", start_cnt - s0, 0);
    rd_idx = act_q.size();
    push_reply(SMAC, SIP);
    s0 = start_cnt;
    send(64, 1'b0, t_end);
    wait_start(s0, "t11_start");
    score("t11_wr");
    chk("t11_cnt", arp_req_cnt, 1);
    chk("t11_pcmac", PC_MAC, SMAC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
